// File: rtl/clk_div_pkg.sv
// Shared encodings for the programmable clock-enable / divided-clock generator.
package clk_div_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam logic MODE_TOGGLE = 1'b0;
  localparam logic MODE_PULSE  = 1'b1;

endpackage

// File: rtl/clk_div_gen_if.sv
// Control/status bundle of clk_div_gen: run control, divisor reload handshake, divided outputs.
interface clk_div_gen_if #(
  parameter int WIDTH = 26
);
  logic             en;
  logic             mode;
  logic [WIDTH-1:0] div_in;
  logic             div_load;
  logic             div_ack;
  logic             pending;
  logic             tick;
  logic             clk_operating;
  logic [WIDTH-1:0] count;

  modport master (
    output en, mode, div_in, div_load,
    input  div_ack, pending, tick, clk_operating, count
  );

  modport slave (
    input  en, mode, div_in, div_load,
    output div_ack, pending, tick, clk_operating, count
  );
endinterface

// File: rtl/clk_div_reload.sv
// Divisor reload staging: latest-wins pending register, pending flag and one-cycle ack.
// A load coincident with apply_i wins, so the freshly captured value stays pending.
module clk_div_reload #(
  parameter int WIDTH = 26
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             div_load_i,
  input  logic [WIDTH-1:0] div_in_i,
  input  logic             apply_i,
  output logic [WIDTH-1:0] pend_val_o,
  output logic             pending_o,
  output logic             div_ack_o
);

  logic [WIDTH-1:0] pend_val_q;
  logic             pending_q;
  logic             ack_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      pend_val_q <= '0;
      pending_q  <= 1'b0;
      ack_q      <= 1'b0;
    end else begin
      ack_q <= div_load_i;
      if (div_load_i) begin
        pend_val_q <= div_in_i;
        pending_q  <= 1'b1;
      end else if (apply_i) begin
        pending_q  <= 1'b0;
      end
    end
  end

  assign pend_val_o = pend_val_q;
  assign pending_o  = pending_q;
  assign div_ack_o  = ack_q;

endmodule

// File: rtl/clk_div_gen.sv
// Run-time programmable tick / divided-clock generator; all outputs registered.
// The divisor and mode only change at period boundaries (wrap) or while idle.
module clk_div_gen
  import clk_div_pkg::*;
#(
  parameter int WIDTH       = 26,
  parameter int DEFAULT_DIV = 50_000_000
) (
  input  logic          clk,
  input  logic          rst,
  clk_div_gen_if.slave  bus
);

  state_e           state_q;
  logic [WIDTH-1:0] div_q;
  logic [WIDTH-1:0] count_q;
  logic             mode_q;
  logic             tick_q;
  logic             clk_op_q;

  logic [WIDTH-1:0] deff;
  logic [WIDTH-1:0] pend_val;
  logic             pending;
  logic             wrap;
  logic             apply;

  // A zero divisor behaves as one.
  assign deff  = (div_q == '0) ? WIDTH'(1) : div_q;
  assign wrap  = (state_q == ST_RUN) && bus.en && (count_q == deff - WIDTH'(1));
  assign apply = pending && ((state_q == ST_IDLE) || !bus.en || wrap);

  clk_div_reload #(.WIDTH(WIDTH)) u_reload (
    .clk        (clk),
    .rst        (rst),
    .div_load_i (bus.div_load),
    .div_in_i   (bus.div_in),
    .apply_i    (apply),
    .pend_val_o (pend_val),
    .pending_o  (pending),
    .div_ack_o  (bus.div_ack)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      div_q    <= WIDTH'(DEFAULT_DIV);
      count_q  <= '0;
      mode_q   <= MODE_TOGGLE;
      tick_q   <= 1'b0;
      clk_op_q <= 1'b0;
    end else begin
      if (apply) div_q <= pend_val;
      case (state_q)
        ST_IDLE: begin
          mode_q   <= bus.mode;
          count_q  <= '0;
          tick_q   <= 1'b0;
          clk_op_q <= 1'b0;
          if (bus.en) state_q <= ST_RUN;
        end
        default: begin
          if (!bus.en) begin
            state_q  <= ST_IDLE;
            count_q  <= '0;
            tick_q   <= 1'b0;
            clk_op_q <= 1'b0;
          end else if (wrap) begin
            count_q  <= '0;
            tick_q   <= 1'b1;
            mode_q   <= bus.mode;
            clk_op_q <= (bus.mode == MODE_PULSE) ? 1'b1 : ~clk_op_q;
          end else begin
            count_q  <= count_q + WIDTH'(1);
            tick_q   <= 1'b0;
            // Pulse mode mirrors tick; toggle mode holds its half-period.
            if (mode_q == MODE_PULSE) clk_op_q <= 1'b0;
          end
        end
      endcase
    end
  end

  assign bus.pending       = pending;
  assign bus.tick          = tick_q;
  assign bus.clk_operating = clk_op_q;
  assign bus.count         = count_q;

endmodule
